// File: rtl/memory_buffer_arb.sv
// Banked 1W1R buffer shared by a serial port (m0) and a per-bank parallel port (m1); m1 has priority with an m0 starvation guard.
// Grants are combinational, reads return one cycle later; denied ops are dropped and must be retried by the requester.
module memory_buffer_arb #(
  parameter int N_BUF      = 8,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int SEL_W      = $clog2(N_BUF),
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [SEL_W-1:0]          m0_sel,
  input  logic [ADDR_W-1:0]         m0_addr,
  input  logic [WIDTH-1:0]          m0_w_data,
  output logic                      m0_gnt,
  output logic                      m0_r_valid,
  output logic [WIDTH-1:0]          m0_r_data,
  output logic                      m0_err,
  input  logic [N_BUF-1:0]          m1_w_en,
  input  logic [N_BUF-1:0]          m1_r_en,
  input  logic [N_BUF*ADDR_W-1:0]   m1_w_addr,
  input  logic [N_BUF*ADDR_W-1:0]   m1_r_addr,
  input  logic [N_BUF*WIDTH-1:0]    m1_w_data,
  output logic [N_BUF-1:0]          m1_gnt,
  output logic [N_BUF-1:0]          m1_r_valid,
  output logic [N_BUF*WIDTH-1:0]    m1_r_data,
  output logic [15:0]               conflict_cnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [WIDTH-1:0]  mem [N_BUF][DEPTH];

  logic [WIDTH-1:0]  bank_rd_q [N_BUF];
  logic [WIDTH-1:0]  bank_rd_d [N_BUF];
  logic [N_BUF-1:0]  m1_r_valid_q, m1_r_valid_d;
  logic              m0_r_valid_q, m0_r_valid_d;
  logic [SEL_W-1:0]  m0_sel_q, m0_sel_d;
  logic              m0_err_q, m0_err_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              sel_ok, m0_act, conflict, m0_force;
  logic [N_BUF-1:0]  sel_hit, m1_op_vec;
  logic [N_BUF-1:0]  m0_wr, m0_rd, m1_wr_ok, m1_rd_ok, wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr [N_BUF];
  logic [ADDR_W-1:0] rd_addr [N_BUF];
  logic [WIDTH-1:0]  wr_data [N_BUF];

  always_comb begin
    sel_ok = int'(m0_sel) < N_BUF;
    m0_act = m0_req && sel_ok;
    for (int b = 0; b < N_BUF; b++) begin
      sel_hit[b] = m0_act && (m0_sel == SEL_W'(b));
    end
    // Only the same port type on the same bank competes with m0.
    m1_op_vec = m0_we ? m1_w_en : m1_r_en;
    conflict  = |(sel_hit & m1_op_vec);
    m0_force  = conflict && (starve_q == CNT_W'(STARVE_MAX));
    m0_gnt    = m0_act && (!conflict || m0_force);
    m1_gnt    = ~(sel_hit & {N_BUF{m0_force}});
    m1_wr_ok  = m1_w_en & ~(sel_hit & {N_BUF{m0_force && m0_we}});
    m1_rd_ok  = m1_r_en & ~(sel_hit & {N_BUF{m0_force && !m0_we}});
    m0_wr     = sel_hit & {N_BUF{m0_gnt && m0_we}};
    m0_rd     = sel_hit & {N_BUF{m0_gnt && !m0_we}};
    wr_en     = m0_wr | m1_wr_ok;
    rd_en     = m0_rd | m1_rd_ok;
  end

  always_comb begin
    for (int b = 0; b < N_BUF; b++) begin
      wr_addr[b]   = m0_wr[b] ? m0_addr   : m1_w_addr[b*ADDR_W +: ADDR_W];
      wr_data[b]   = m0_wr[b] ? m0_w_data : m1_w_data[b*WIDTH +: WIDTH];
      rd_addr[b]   = m0_rd[b] ? m0_addr   : m1_r_addr[b*ADDR_W +: ADDR_W];
      bank_rd_d[b] = rd_en[b] ? mem[b][rd_addr[b]] : bank_rd_q[b];
    end
  end

  always_comb begin
    m1_r_valid_d = m1_rd_ok;
    m0_r_valid_d = m0_gnt && !m0_we;
    m0_sel_d     = (m0_gnt && !m0_we) ? m0_sel : m0_sel_q;
    m0_err_d     = m0_err_q || (m0_req && !sel_ok);
    starve_d     = starve_q;
    conflict_cnt_d = conflict_cnt_q;
    if (!m0_req || m0_gnt) begin
      starve_d = '0;
    end else if (conflict) begin
      starve_d = starve_q + CNT_W'(1);
    end
    if (conflict && !m0_force && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BUF; b++) begin
      if (wr_en[b]) mem[b][wr_addr[b]] <= wr_data[b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N_BUF; b++) bank_rd_q[b] <= '0;
      m1_r_valid_q   <= '0;
      m0_r_valid_q   <= 1'b0;
      m0_sel_q       <= '0;
      m0_err_q       <= 1'b0;
      conflict_cnt_q <= '0;
      starve_q       <= '0;
    end else begin
      for (int b = 0; b < N_BUF; b++) bank_rd_q[b] <= bank_rd_d[b];
      m1_r_valid_q   <= m1_r_valid_d;
      m0_r_valid_q   <= m0_r_valid_d;
      m0_sel_q       <= m0_sel_d;
      m0_err_q       <= m0_err_d;
      conflict_cnt_q <= conflict_cnt_d;
      starve_q       <= starve_d;
    end
  end

  always_comb begin
    m0_r_data = '0;
    for (int b = 0; b < N_BUF; b++) begin
      m1_r_data[b*WIDTH +: WIDTH] = bank_rd_q[b];
      if (m0_sel_q == SEL_W'(b)) m0_r_data = bank_rd_q[b];
    end
  end

  assign m0_r_valid   = m0_r_valid_q;
  assign m1_r_valid   = m1_r_valid_q;
  assign m0_err       = m0_err_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_memory_buffer_arb.sv
module tb_memory_buffer_arb;
  localparam int N_BUF = 8;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam int SEL_W = 4;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we;
  logic [SEL_W-1:0] m0_sel;
  logic [ADDR_W-1:0] m0_addr;
  logic [WIDTH-1:0] m0_w_data;
  logic m0_gnt, m0_r_valid, m0_err;
  logic [WIDTH-1:0] m0_r_data;
  logic [N_BUF-1:0] m1_w_en, m1_r_en, m1_gnt, m1_r_valid;
  logic [N_BUF*ADDR_W-1:0] m1_w_addr, m1_r_addr;
  logic [N_BUF*WIDTH-1:0] m1_w_data, m1_r_data;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_buffer_arb #(.N_BUF(N_BUF), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                      .SEL_W(SEL_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_w_data(m0_w_data),
    .m0_gnt(m0_gnt), .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_err(m0_err),
    .m1_w_en(m1_w_en), .m1_r_en(m1_r_en), .m1_w_addr(m1_w_addr), .m1_r_addr(m1_r_addr),
    .m1_w_data(m1_w_data), .m1_gnt(m1_gnt), .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data),
    .conflict_cnt(conflict_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_addr = '0; m0_w_data = '0;
    m1_w_en = '0; m1_r_en = '0; m1_w_addr = '0; m1_r_addr = '0; m1_w_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    checks++; if (m0_r_valid !== 1'b0) begin failures++; $display("FAIL reset_m0_r_valid got=%0h exp=0", m0_r_valid); end
    checks++; if (m1_r_valid !== 8'h00) begin failures++; $display("FAIL reset_m1_r_valid got=%0h exp=0", m1_r_valid); end
    checks++; if (m0_r_data !== 16'h0) begin failures++; $display("FAIL reset_m0_r_data got=%0h exp=0", m0_r_data); end
    checks++; if (m1_r_data !== '0) begin failures++; $display("FAIL reset_m1_r_data got=%0h exp=0", m1_r_data); end
    checks++; if (m0_err !== 1'b0) begin failures++; $display("FAIL reset_m0_err got=%0h exp=0", m0_err); end
    checks++; if (conflict_cnt !== 16'h0) begin failures++; $display("FAIL reset_conflict_cnt got=%0h exp=0", conflict_cnt); end
  endtask

  task automatic test_m0_rw();
    idle();
    m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'd3; m0_addr = 10'd5; m0_w_data = 16'hBEEF;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL m0_wr_gnt got=%0h exp=1", m0_gnt); end
    tick();
    m0_we = 1'b0;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL m0_rd_gnt got=%0h exp=1", m0_gnt); end
    tick();
    checks++; if (m0_r_valid !== 1'b1) begin failures++; $display("FAIL m0_rd_valid got=%0h exp=1", m0_r_valid); end
    checks++; if (m0_r_data !== 16'hBEEF) begin failures++; $display("FAIL m0_rd_data got=%0h exp=beef", m0_r_data); end
    m0_req = 1'b0;
    tick();
    checks++; if (m0_r_valid !== 1'b0) begin failures++; $display("FAIL m0_valid_strobe got=%0h exp=0", m0_r_valid); end
    checks++; if (m0_r_data !== 16'hBEEF) begin failures++; $display("FAIL m0_data_hold got=%0h exp=beef", m0_r_data); end
  endtask

  task automatic test_m1_all();
    idle();
    m1_w_en = 8'hFF;
    for (int b = 0; b < N_BUF; b++) m1_w_data[b*WIDTH +: WIDTH] = WIDTH'(b);
    #1;
    checks++; if (m1_gnt !== 8'hFF) begin failures++; $display("FAIL m1_wr_gnt got=%0h exp=ff", m1_gnt); end
    tick();
    m1_w_en = 8'h00; m1_r_en = 8'hFF;
    tick();
    checks++; if (m1_r_valid !== 8'hFF) begin failures++; $display("FAIL m1_rd_valid got=%0h exp=ff", m1_r_valid); end
    for (int b = 0; b < N_BUF; b++) begin
      checks++;
      if (m1_r_data[b*WIDTH +: WIDTH] !== WIDTH'(b)) begin
        failures++; $display("FAIL m1_rd_data bank=%0d got=%0h exp=%0h", b, m1_r_data[b*WIDTH +: WIDTH], b);
      end
    end
    m1_r_en = 8'h00;
    tick();
    checks++; if (m1_r_valid !== 8'h00) begin failures++; $display("FAIL m1_valid_strobe got=%0h exp=0", m1_r_valid); end
  endtask

  task automatic test_starve();
    idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_sel = 4'd2; m0_addr = 10'd0;
    m1_r_en = 8'h04;
    for (int i = 0; i < STARVE_MAX; i++) begin
      #1;
      checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL starve_deny cyc=%0d got=%0h exp=0", i, m0_gnt); end
      checks++; if (m1_gnt !== 8'hFF) begin failures++; $display("FAIL starve_m1_gnt cyc=%0d got=%0h exp=ff", i, m1_gnt); end
      tick();
    end
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL starve_force got=%0h exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 8'hFB) begin failures++; $display("FAIL starve_m1_deny got=%0h exp=fb", m1_gnt); end
    tick();
    checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL starve_cnt got=%0d exp=4", conflict_cnt); end
    checks++; if (m0_r_valid !== 1'b1) begin failures++; $display("FAIL starve_m0_valid got=%0h exp=1", m0_r_valid); end
    checks++; if (m0_r_data !== 16'd2) begin failures++; $display("FAIL starve_m0_data got=%0h exp=2", m0_r_data); end
    checks++; if (m1_r_valid !== 8'h00) begin failures++; $display("FAIL starve_m1_valid got=%0h exp=0", m1_r_valid); end
    idle();
    tick();
  endtask

  task automatic test_rw_same();
    idle();
    m1_w_en = 8'h02; m1_w_addr[1*ADDR_W +: ADDR_W] = 10'd7; m1_w_data[1*WIDTH +: WIDTH] = 16'h0011;
    tick();
    idle();
    m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'd1; m0_addr = 10'd7; m0_w_data = 16'h0022;
    m1_r_en = 8'h02; m1_r_addr[1*ADDR_W +: ADDR_W] = 10'd7;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rwsame_m0_gnt got=%0h exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 8'hFF) begin failures++; $display("FAIL rwsame_m1_gnt got=%0h exp=ff", m1_gnt); end
    tick();
    checks++; if (m1_r_data[1*WIDTH +: WIDTH] !== 16'h0011) begin failures++; $display("FAIL rwsame_old got=%0h exp=0011", m1_r_data[1*WIDTH +: WIDTH]); end
    m0_req = 1'b0;
    tick();
    checks++; if (m1_r_valid !== 8'h02) begin failures++; $display("FAIL rwsame_valid got=%0h exp=02", m1_r_valid); end
    checks++; if (m1_r_data[1*WIDTH +: WIDTH] !== 16'h0022) begin failures++; $display("FAIL rwsame_new got=%0h exp=0022", m1_r_data[1*WIDTH +: WIDTH]); end
    idle();
  endtask

  task automatic test_bad_sel();
    idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_sel = 4'd9;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL badsel_gnt got=%0h exp=0", m0_gnt); end
    tick();
    checks++; if (m0_err !== 1'b1) begin failures++; $display("FAIL badsel_err got=%0h exp=1", m0_err); end
    checks++; if (m0_r_valid !== 1'b0) begin failures++; $display("FAIL badsel_valid got=%0h exp=0", m0_r_valid); end
    idle();
    tick(); tick(); tick();
    checks++; if (m0_err !== 1'b1) begin failures++; $display("FAIL badsel_sticky got=%0h exp=1", m0_err); end
    checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL badsel_cnt got=%0d exp=4", conflict_cnt); end
  endtask

  task automatic test_reset_inflight();
    idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_sel = 4'd3; m0_addr = 10'd5;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rstfl_gnt got=%0h exp=1", m0_gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++; if (m0_r_valid !== 1'b0) begin failures++; $display("FAIL rstfl_valid got=%0h exp=0", m0_r_valid); end
    checks++; if (m0_err !== 1'b0) begin failures++; $display("FAIL rstfl_err got=%0h exp=0", m0_err); end
    checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL rstfl_cnt got=%0d exp=0", conflict_cnt); end
    checks++; if (m0_r_data !== 16'd0) begin failures++; $display("FAIL rstfl_m0_data got=%0h exp=0", m0_r_data); end
    checks++; if (m1_r_data !== '0) begin failures++; $display("FAIL rstfl_m1_data got=%0h exp=0", m1_r_data); end
    tick();
    checks++; if (m0_r_valid !== 1'b0) begin failures++; $display("FAIL rstfl_valid_after got=%0h exp=0", m0_r_valid); end
  endtask

  // Reference model: banks as plain arrays over a 4-word window at address 16..19.
  task automatic test_random();
    logic [15:0] ref_mem [N_BUF][4];
    bit          known [N_BUF][4];
    int          starve_run, denied_total, sel, m0_a;
    bit          err_seen, valid_sel, clash, m0_wins, exp_m0_gnt, exp_m0_rd, exp_m0_known;
    logic [15:0] exp_m0_data;
    logic [7:0]  exp_m1_gnt, exp_m1_valid;
    logic [15:0] exp_m1_data [N_BUF];
    bit          exp_m1_known [N_BUF];
    int          wa [N_BUF];
    int          ra [N_BUF];
    starve_run = 0; denied_total = 0; err_seen = 1'b0;
    for (int b = 0; b < N_BUF; b++) for (int a = 0; a < 4; a++) known[b][a] = 1'b0;
    for (int it = 0; it < 400; it++) begin
      m0_req = ($urandom_range(0, 3) != 0);
      m0_we = $urandom_range(0, 1) == 1;
      m0_sel = ($urandom_range(0, 19) == 0) ? SEL_W'(8 + $urandom_range(0, 7)) : SEL_W'($urandom_range(0, 7));
      m0_a = $urandom_range(0, 3);
      m0_addr = ADDR_W'(16 + m0_a);
      m0_w_data = WIDTH'($urandom);
      m1_w_en = 8'($urandom & $urandom);
      m1_r_en = 8'($urandom | $urandom);
      for (int b = 0; b < N_BUF; b++) begin
        wa[b] = $urandom_range(0, 3);
        ra[b] = $urandom_range(0, 3);
        m1_w_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(16 + wa[b]);
        m1_r_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(16 + ra[b]);
        m1_w_data[b*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      sel = int'(m0_sel);
      valid_sel = m0_req && sel < N_BUF;
      clash = valid_sel && (m0_we ? m1_w_en[sel] : m1_r_en[sel]);
      m0_wins = clash && starve_run == STARVE_MAX;
      exp_m0_gnt = valid_sel && (!clash || m0_wins);
      exp_m1_gnt = 8'hFF;
      if (m0_wins) exp_m1_gnt[sel] = 1'b0;
      #1;
      checks++; if (m0_gnt !== exp_m0_gnt) begin failures++; $display("FAIL rnd_m0_gnt it=%0d got=%0h exp=%0h", it, m0_gnt, exp_m0_gnt); end
      checks++; if (m1_gnt !== exp_m1_gnt) begin failures++; $display("FAIL rnd_m1_gnt it=%0d got=%0h exp=%0h", it, m1_gnt, exp_m1_gnt); end
      // Reads see contents before this cycle's writes.
      for (int b = 0; b < N_BUF; b++) begin
        exp_m1_valid[b] = m1_r_en[b] && !(m0_wins && b == sel && !m0_we);
        exp_m1_data[b] = ref_mem[b][ra[b]];
        exp_m1_known[b] = known[b][ra[b]];
      end
      exp_m0_rd = exp_m0_gnt && !m0_we;
      if (exp_m0_rd) begin
        exp_m0_data = ref_mem[sel][m0_a];
        exp_m0_known = known[sel][m0_a];
      end else begin
        exp_m0_data = '0;
        exp_m0_known = 1'b0;
      end
      for (int b = 0; b < N_BUF; b++) begin
        if (m1_w_en[b] && !(m0_wins && b == sel && m0_we)) begin
          ref_mem[b][wa[b]] = m1_w_data[b*WIDTH +: WIDTH];
          known[b][wa[b]] = 1'b1;
        end
      end
      if (exp_m0_gnt && m0_we) begin
        ref_mem[sel][m0_a] = m0_w_data;
        known[sel][m0_a] = 1'b1;
      end
      if (clash && !m0_wins && denied_total < 65535) denied_total++;
      if (!m0_req || exp_m0_gnt) starve_run = 0;
      else if (clash) starve_run++;
      if (m0_req && sel >= N_BUF) err_seen = 1'b1;
      tick();
      checks++; if (m1_r_valid !== exp_m1_valid) begin failures++; $display("FAIL rnd_m1_valid it=%0d got=%0h exp=%0h", it, m1_r_valid, exp_m1_valid); end
      for (int b = 0; b < N_BUF; b++) begin
        if (exp_m1_valid[b] && exp_m1_known[b]) begin
          checks++;
          if (m1_r_data[b*WIDTH +: WIDTH] !== exp_m1_data[b]) begin
            failures++; $display("FAIL rnd_m1_data it=%0d bank=%0d got=%0h exp=%0h", it, b, m1_r_data[b*WIDTH +: WIDTH], exp_m1_data[b]);
          end
        end
      end
      checks++; if (m0_r_valid !== exp_m0_rd) begin failures++; $display("FAIL rnd_m0_valid it=%0d got=%0h exp=%0h", it, m0_r_valid, exp_m0_rd); end
      if (exp_m0_rd && exp_m0_known) begin
        checks++; if (m0_r_data !== exp_m0_data) begin failures++; $display("FAIL rnd_m0_data it=%0d got=%0h exp=%0h", it, m0_r_data, exp_m0_data); end
      end
      checks++; if (conflict_cnt !== 16'(denied_total)) begin failures++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, conflict_cnt, denied_total); end
      checks++; if (m0_err !== err_seen) begin failures++; $display("FAIL rnd_err it=%0d got=%0h exp=%0h", it, m0_err, err_seen); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_m0_rw();
    test_m1_all();
    test_starve();
    test_rw_same();
    test_bad_sel();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
